// File: rtl/ternary_fabric_pkg.sv
// Shared trit encodings and responder FSM state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ternary_fabric_pkg;

  // Two-bit trit codes as stored in the backing SRAM.
  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b10;
  localparam logic [1:0] TRIT_BAD  = 2'b11;

  localparam int unsigned SRAM_DW = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_GAP
  } state_e;

endpackage

// File: rtl/trit_lane_decode.sv
// Sanitises one 2-bit trit code: the unused code becomes zero and is flagged.
// Latency: combinational.
// Backpressure: none.
// Ports: code_i raw code; code_o sanitised code; bad_o high when code_i was illegal.
module trit_lane_decode
  import ternary_fabric_pkg::*;
(
  input  logic [1:0] code_i,
  output logic [1:0] code_o,
  output logic       bad_o
);

  always_comb begin
    code_o = TRIT_ZERO;
    bad_o  = 1'b0;
    case (code_i)
      TRIT_ZERO, TRIT_POS, TRIT_NEG: code_o = code_i;
      default:                       bad_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/frame_mem_responder.sv
// Serves lane-word reads for the frame controller from a fixed-latency SRAM.
// Latency: mem_ready in the SRAM_LATENCY+2-th cycle after req_valid is first
//   presented in IDLE (2 cycles for an out-of-window address).
// Backpressure: none; dropping req_valid before RESP abandons the request.
// Ports: clk/reset (sync, active-high); req_valid/req_addr request in;
//   mem_ready/rd_data one-cycle response; sram_en/sram_addr/sram_rdata SRAM
//   read port; resp_count responses this frame; addr_err/trit_err sticky flags.
module frame_mem_responder
  import ternary_fabric_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           LANE_COUNT   = 15,
  parameter int unsigned           SRAM_LATENCY = 1,   // legal range 1..4
  parameter logic [ADDR_WIDTH-1:0] WIN_BASE     = '0,
  parameter logic [ADDR_WIDTH-1:0] WIN_SIZE     = ADDR_WIDTH'(32'h0001_0000)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  output logic                    mem_ready,
  output logic [2*LANE_COUNT-1:0] rd_data,
  output logic                    sram_en,
  output logic [ADDR_WIDTH-3:0]   sram_addr,
  input  logic [SRAM_DW-1:0]      sram_rdata,
  output logic [15:0]             resp_count,
  output logic                    addr_err,
  output logic                    trit_err
);

  localparam int unsigned DW = 2 * LANE_COUNT;
  localparam logic [1:0]  WAIT_LAST = 2'(SRAM_LATENCY - 1);

  // Window bounds carried one bit wider so WIN_BASE+WIN_SIZE cannot wrap.
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, WIN_BASE};
  localparam logic [ADDR_WIDTH:0] WIN_HI = {1'b0, WIN_BASE} + {1'b0, WIN_SIZE};

  state_e                  state_q;
  logic                    req_valid_q;
  logic                    in_win_q;
  logic                    abort_q;
  logic [1:0]              wcnt_q;
  logic                    mem_ready_q;
  logic [DW-1:0]           rd_data_q;
  logic                    sram_en_q;
  logic [ADDR_WIDTH-3:0]   sram_addr_q;
  logic [15:0]             resp_count_q;
  logic                    addr_err_q;
  logic                    trit_err_q;

  logic                    in_win_d;
  logic [DW-1:0]           dec_dat_d;
  logic [LANE_COUNT-1:0]   lane_bad_d;

  assign in_win_d = ({1'b0, req_addr} >= WIN_LO) && ({1'b0, req_addr} < WIN_HI);

  for (genvar g = 0; g < LANE_COUNT; g++) begin : g_lane
    trit_lane_decode u_dec (
      .code_i (sram_rdata[2*g +: 2]),
      .code_o (dec_dat_d[2*g +: 2]),
      .bad_o  (lane_bad_d[g])
    );
  end

  // SRAM bits above the packed lanes carry nothing for this block.
  if (DW < SRAM_DW) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^sram_rdata[SRAM_DW-1:DW];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_valid_q  <= 1'b0;
      in_win_q     <= 1'b0;
      abort_q      <= 1'b0;
      wcnt_q       <= '0;
      mem_ready_q  <= 1'b0;
      rd_data_q    <= '0;
      sram_en_q    <= 1'b0;
      sram_addr_q  <= '0;
      resp_count_q <= '0;
      addr_err_q   <= 1'b0;
      trit_err_q   <= 1'b0;
    end else begin
      req_valid_q <= req_valid;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            // A fresh rise of req_valid marks a new frame.
            if (!req_valid_q) resp_count_q <= '0;
            sram_addr_q <= req_addr[ADDR_WIDTH-1:2];
            in_win_q    <= in_win_d;
            sram_en_q   <= in_win_d;
            abort_q     <= 1'b0;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          sram_en_q <= 1'b0;
          wcnt_q    <= '0;
          if (!in_win_q) begin
            addr_err_q <= 1'b1;
            if (req_valid) begin
              rd_data_q    <= '0;
              mem_ready_q  <= 1'b1;
              resp_count_q <= resp_count_q + 16'd1;
              state_q      <= ST_RESP;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            // The SRAM read is already launched; let it drain even if abandoned.
            abort_q <= !req_valid;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wcnt_q == WAIT_LAST) begin
            if (abort_q || !req_valid) begin
              state_q <= ST_IDLE;
            end else begin
              rd_data_q    <= dec_dat_d;
              if (|lane_bad_d) trit_err_q <= 1'b1;
              mem_ready_q  <= 1'b1;
              resp_count_q <= resp_count_q + 16'd1;
              state_q      <= ST_RESP;
            end
          end else begin
            wcnt_q <= wcnt_q + 2'd1;
            if (!req_valid) abort_q <= 1'b1;
          end
        end
        ST_RESP: begin
          mem_ready_q <= 1'b0;
          state_q     <= ST_GAP;
        end
        ST_GAP: begin
          // Gives the requester a cycle to move req_addr before IDLE samples it.
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_ready  = mem_ready_q;
  assign rd_data    = rd_data_q;
  assign sram_en    = sram_en_q;
  assign sram_addr  = sram_addr_q;
  assign resp_count = resp_count_q;
  assign addr_err   = addr_err_q;
  assign trit_err   = trit_err_q;

endmodule

// File: tb/tb_frame_mem_responder.sv
// Bench for frame_mem_responder: SRAM_LATENCY=1 and SRAM_LATENCY=3 instances.
// Expected responses are queued at request time and popped by per-instance monitors.
module tb_frame_mem_responder;

  localparam int DW = 30;
  localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic          rv1, rv3;
  logic [31:0]   ra1, ra3;
  logic          mr1, mr3;
  logic [DW-1:0] rd1, rd3;
  logic          en1, en3;
  logic [29:0]   sa1, sa3;
  logic [31:0]   sd1, sd3;
  logic [15:0]   rc1, rc3;
  logic          ae1, ae3, te1, te3;

  frame_mem_responder #(.SRAM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(rv1), .req_addr(ra1),
    .mem_ready(mr1), .rd_data(rd1), .sram_en(en1), .sram_addr(sa1),
    .sram_rdata(sd1), .resp_count(rc1), .addr_err(ae1), .trit_err(te1)
  );

  frame_mem_responder #(.SRAM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(rv3), .req_addr(ra3),
    .mem_ready(mr3), .rd_data(rd3), .sram_en(en3), .sram_addr(sa3),
    .sram_rdata(sd3), .resp_count(rc3), .addr_err(ae3), .trit_err(te3)
  );

  // SRAM models: data is valid only in the one cycle SRAM_LATENCY after sram_en.
  logic [31:0] mem1 [16];
  logic [31:0] mem3 [16];
  logic       v3a = 1'b0, v3b = 1'b0;
  logic [3:0] a3a = '0, a3b = '0;

  always @(posedge clk) sd1 <= en1 ? mem1[sa1[3:0]] : JUNK;

  always @(posedge clk) begin
    v3a <= en3;
    a3a <= sa3[3:0];
    v3b <= v3a;
    a3b <= a3a;
    sd3 <= v3b ? mem3[a3b] : JUNK;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] dat;
    int            issue;
    int            lat;     // 0 = latency not checked
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  logic mr1_prev = 1'b0, mr3_prev = 1'b0;
  int   en1_cnt = 0, en3_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (en1 === 1'b1) en1_cnt++;
    if (mr1 === 1'b1) begin
      chk("dut1_pulse_gap", {63'd0, mr1_prev}, 64'd0);
      chk("dut1_resp_expected", {63'd0, q1.size() > 0}, 64'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("dut1_rd_data", {34'd0, rd1}, {34'd0, e.dat});
        if (e.lat != 0) chk("dut1_latency", 64'(cyc - e.issue), 64'(e.lat));
      end
    end
    mr1_prev = (mr1 === 1'b1);
  end

  always @(negedge clk) begin
    exp_t e;
    if (en3 === 1'b1) en3_cnt++;
    if (mr3 === 1'b1) begin
      chk("dut3_pulse_gap", {63'd0, mr3_prev}, 64'd0);
      chk("dut3_resp_expected", {63'd0, q3.size() > 0}, 64'd1);
      if (q3.size() > 0) begin
        e = q3.pop_front();
        chk("dut3_rd_data", {34'd0, rd3}, {34'd0, e.dat});
        if (e.lat != 0) chk("dut3_latency", 64'(cyc - e.issue), 64'(e.lat));
      end
    end
    mr3_prev = (mr3 === 1'b1);
  end

  // Presents a request at a negedge, queues the expected response and waits
  // (bounded) until the RESP cycle; returns at that negedge with req_valid still high.
  task automatic req(input int d, input logic [31:0] a, input logic [DW-1:0] dat, input int lat);
    exp_t e;
    logic en, mr;
    logic [29:0] sa;
    e.dat = dat; e.issue = cyc; e.lat = lat;
    if (d == 1) begin rv1 = 1'b1; ra1 = a; q1.push_back(e); end
    else        begin rv3 = 1'b1; ra3 = a; q3.push_back(e); end
    mr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      en = (d == 1) ? en1 : en3;
      sa = (d == 1) ? sa1 : sa3;
      mr = (d == 1) ? mr1 : mr3;
      if (en === 1'b1) chk("sram_addr", {34'd0, sa}, {34'd0, a[31:2]});
      if (mr === 1'b1) break;
    end
    if (mr !== 1'b1) chk("resp_timeout", {63'd0, mr}, 64'd1);
  endtask

  task automatic end_frame(input int d, input int n);
    if (d == 1) rv1 = 1'b0; else rv3 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    rv1 = 1'b0; rv3 = 1'b0; ra1 = '0; ra3 = '0;
    for (int i = 0; i < 16; i++) begin mem1[i] = JUNK; mem3[i] = JUNK; end
    mem1[4]  = 32'h1555_5555;
    mem1[15] = 32'h0AAA_5555;
    mem1[5]  = 32'h0000_0003;
    mem1[6]  = 32'hFC00_00E7;   // lanes 0,3,13,14 illegal; bits 31:30 ignored
    mem1[7]  = 32'h2222_1111;
    mem1[8]  = 32'h0101_0101;
    mem1[9]  = 32'h0202_0202;
    mem1[10] = 32'h1010_1010;
    mem1[11] = 32'h2020_2020;
    mem3[4]  = 32'h0555_0001;
    mem3[5]  = 32'h1111_1111;
    mem3[6]  = 32'h2002_2002;
    mem3[7]  = 32'h0000_0001;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_mem_ready",  {63'd0, mr1}, 64'd0);
    chk("rst_sram_en",    {63'd0, en1}, 64'd0);
    chk("rst_sram_addr",  {34'd0, sa1}, 64'd0);
    chk("rst_rd_data",    {34'd0, rd1}, 64'd0);
    chk("rst_resp_count", {48'd0, rc1}, 64'd0);
    chk("rst_addr_err",   {63'd0, ae1}, 64'd0);
    chk("rst_trit_err",   {63'd0, te1}, 64'd0);
    chk("rst3_mem_ready", {63'd0, mr3}, 64'd0);
    chk("rst3_resp_count",{48'd0, rc3}, 64'd0);
    @(negedge clk);

    // Basic read, L=1: word address 4, response in the third cycle.
    req(1, 32'h0000_0010, 30'h1555_5555, 3);
    end_frame(1, 3);
    chk("basic_resp_count", {48'd0, rc1}, 64'd1);
    chk("basic_addr_err",   {63'd0, ae1}, 64'd0);
    chk("basic_trit_err",   {63'd0, te1}, 64'd0);
    chk("basic_rd_hold",    {34'd0, rd1}, 64'h1555_5555);

    // Last legal word of the window.
    req(1, 32'h0000_FFFC, 30'h0AAA_5555, 3);
    end_frame(1, 3);
    chk("win_last_addr_err", {63'd0, ae1}, 64'd0);

    // Window end: no SRAM access, zero data, two-cycle response.
    req(1, 32'h0001_0000, 30'h0, 2);
    end_frame(1, 3);
    chk("oow_addr_err",   {63'd0, ae1}, 64'd1);
    chk("oow_resp_count", {48'd0, rc1}, 64'd1);
    chk("oow_rd_hold",    {34'd0, rd1}, 64'd0);

    // Illegal trit codes in one frame, then a clean read: trit_err stays set.
    req(1, 32'h0000_0014, 30'h0, 3);
    chk("trit_err_set", {63'd0, te1}, 64'd1);
    req(1, 32'h0000_0018, 30'h0000_0024, 0);
    req(1, 32'h0000_001C, 30'h2222_1111, 0);
    end_frame(1, 3);
    chk("trit_err_sticky",  {63'd0, te1}, 64'd1);
    chk("trit_resp_count",  {48'd0, rc1}, 64'd3);
    chk("trit_rd_hold",     {34'd0, rd1}, 64'h2222_1111);

    // Frame-controller stream: four addresses, stride 4, req_valid held high.
    req(1, 32'h0000_0020, 30'h0101_0101, 3);
    req(1, 32'h0000_0024, 30'h0202_0202, 0);
    req(1, 32'h0000_0028, 30'h1010_1010, 0);
    req(1, 32'h0000_002C, 30'h2020_2020, 0);
    end_frame(1, 3);
    chk("stream_resp_count", {48'd0, rc1}, 64'd4);
    chk("stream_addr_err",   {63'd0, ae1}, 64'd1);

    // L=3: one completed read, then the next request is dropped during WAIT.
    req(3, 32'h0000_0010, 30'h0555_0001, 5);
    ra3 = 32'h0000_0014;
    repeat (4) @(negedge clk);       // GAP, IDLE, ISSUE, first WAIT cycle
    rv3 = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_resp_count", {48'd0, rc3}, 64'd1);
    chk("abort_rd_hold",    {34'd0, rd3}, 64'h0555_0001);
    // A following request proves the FSM went back to IDLE.
    req(3, 32'h0000_0018, 30'h2002_2002, 5);
    end_frame(3, 3);
    chk("post_abort_resp_count", {48'd0, rc3}, 64'd1);

    // Reset while a read is in WAIT.
    rv3 = 1'b1; ra3 = 32'h0000_001C;
    repeat (2) @(negedge clk);       // ISSUE, then first WAIT cycle
    reset = 1'b1;
    @(negedge clk);
    chk("wrst_mem_ready",  {63'd0, mr3}, 64'd0);
    chk("wrst_sram_en",    {63'd0, en3}, 64'd0);
    chk("wrst_sram_addr",  {34'd0, sa3}, 64'd0);
    chk("wrst_rd_data",    {34'd0, rd3}, 64'd0);
    chk("wrst_resp_count", {48'd0, rc3}, 64'd0);
    chk("wrst_dut1_addr_err", {63'd0, ae1}, 64'd0);
    chk("wrst_dut1_trit_err", {63'd0, te1}, 64'd0);
    reset = 1'b0;
    rv3 = 1'b0;
    repeat (10) @(negedge clk);

    chk("dut1_pending", 64'(q1.size()), 64'd0);
    chk("dut3_pending", 64'(q3.size()), 64'd0);
    chk("dut1_sram_reads", 64'(en1_cnt), 64'd9);
    chk("dut3_sram_reads", 64'(en3_cnt), 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
